prim_ram_1p_arb: RTL

- Two-requester front end for one single-port synchronous RAM instance: the generic 1p RAM primitive or its bad-bit fault-injection wrapper.
- Round-robin arbitrates requester A and requester B onto the RAM port, one access per cycle.
- Returns read data with a per-requester rvalid strobe.
- Optionally zero-initialises the whole RAM after reset before granting anyone.

---
 rtl/prim_ram_arb_pkg.sv | 24 ++
 rtl/prim_ram_arb_rr.sv | 48 ++++
 rtl/prim_ram_1p_arb.sv | 135 +++++++++++++
 3 files changed

// File: rtl/prim_ram_arb_pkg.sv
//------------------------------------------------------------------------------
// prim_ram_arb_pkg
// Shared types for the dual-requester single-port RAM arbiter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package prim_ram_arb_pkg;

    localparam int NumReq = 2;

    typedef enum logic [0:0] {
        INIT  = 1'b0,
        SERVE = 1'b1
    } state_e;

    typedef enum logic [0:0] {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_idx_e;

endpackage

`default_nettype wire

// File: rtl/prim_ram_arb_rr.sv
//------------------------------------------------------------------------------
// prim_ram_arb_rr
// Two-way round-robin picker; the pointer moves to the loser on every grant.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module prim_ram_arb_rr
    import prim_ram_arb_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NumReq-1:0] req_i,
    output logic [NumReq-1:0] gnt_o
);

    req_idx_e ptr_q, ptr_d;

    always_comb begin
        gnt_o = '0;
        case (req_i)
            2'b01:   gnt_o[REQ_A] = 1'b1;
            2'b10:   gnt_o[REQ_B] = 1'b1;
            2'b11:   gnt_o[ptr_q] = 1'b1;
            default: gnt_o = '0;
        endcase
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_o[REQ_A]) begin
            ptr_d = REQ_B;
        end else if (gnt_o[REQ_B]) begin
            ptr_d = REQ_A;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= REQ_A;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/prim_ram_1p_arb.sv
//------------------------------------------------------------------------------
// prim_ram_1p_arb
// Round-robin front end sharing one single-port RAM between requesters A and B.
// Optional post-reset zero fill enabled by macro PRIM_RAM_ARB_INIT_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module prim_ram_1p_arb
    import prim_ram_arb_pkg::*;
#(
    parameter  int Width = 32,
    parameter  int Depth = 128,
    localparam int Aw    = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_ni,

    input  logic             a_req_i,
    input  logic             a_write_i,
    input  logic [Aw-1:0]    a_addr_i,
    input  logic [Width-1:0] a_wdata_i,
    input  logic [Width-1:0] a_wmask_i,
    output logic             a_gnt_o,
    output logic             a_rvalid_o,
    output logic [Width-1:0] a_rdata_o,

    input  logic             b_req_i,
    input  logic             b_write_i,
    input  logic [Aw-1:0]    b_addr_i,
    input  logic [Width-1:0] b_wdata_i,
    input  logic [Width-1:0] b_wmask_i,
    output logic             b_gnt_o,
    output logic             b_rvalid_o,
    output logic [Width-1:0] b_rdata_o,

    output logic             ram_req_o,
    output logic             ram_write_o,
    output logic [Aw-1:0]    ram_addr_o,
    output logic [Width-1:0] ram_wdata_o,
    output logic [Width-1:0] ram_wmask_o,
    input  logic [Width-1:0] ram_rdata_i,

    output logic             init_done_o
);

    logic              serve;
    logic [NumReq-1:0] req;
    logic [NumReq-1:0] gnt;
    logic              a_rvalid_q;
    logic              b_rvalid_q;

`ifdef PRIM_RAM_ARB_INIT_EN
    state_e        state_q, state_d;
    logic [Aw-1:0] init_addr_q, init_addr_d;
    logic          init_wr;

    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        if (state_q == INIT) begin
            init_addr_d = init_addr_q + Aw'(1);
            if (init_addr_q == Aw'(Depth - 1)) begin
                state_d = SERVE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= INIT;
            init_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
        end
    end

    assign serve       = (state_q == SERVE);
    // Hold the RAM port quiet while reset is asserted even though the FSM sits in INIT.
    assign init_wr     = (state_q == INIT) & rst_ni;
    assign init_done_o = serve;
`else
    assign serve       = 1'b1;
    assign init_done_o = 1'b1;
`endif

    assign req[REQ_A] = a_req_i & serve;
    assign req[REQ_B] = b_req_i & serve;

    prim_ram_arb_rr u_rr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  (req),
        .gnt_o  (gnt)
    );

    assign a_gnt_o = gnt[REQ_A];
    assign b_gnt_o = gnt[REQ_B];

    always_comb begin
        ram_req_o   = gnt[REQ_A] | gnt[REQ_B];
        ram_write_o = gnt[REQ_B] ? b_write_i : a_write_i;
        ram_addr_o  = gnt[REQ_B] ? b_addr_i  : a_addr_i;
        ram_wdata_o = gnt[REQ_B] ? b_wdata_i : a_wdata_i;
        ram_wmask_o = gnt[REQ_B] ? b_wmask_i : a_wmask_i;
`ifdef PRIM_RAM_ARB_INIT_EN
        if (init_wr) begin
            ram_req_o   = 1'b1;
            ram_write_o = 1'b1;
            ram_addr_o  = init_addr_q;
            ram_wdata_o = '0;
            ram_wmask_o = '1;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
        end else begin
            a_rvalid_q <= gnt[REQ_A] & ~a_write_i;
            b_rvalid_q <= gnt[REQ_B] & ~b_write_i;
        end
    end

    assign a_rvalid_o = a_rvalid_q;
    assign b_rvalid_o = b_rvalid_q;
    assign a_rdata_o  = ram_rdata_i;
    assign b_rdata_o  = ram_rdata_i;

endmodule

`default_nettype wire
